// File: rtl/uop_commit_merger_pkg.sv
// Shared instruction/architecture definitions used by the retire-side micro-op merger
// and the count decoder that it shares with the cracker.
package uop_commit_merger_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_X_FORM = 6'd31;
    localparam logic [5:0] OP_LWZU   = 6'd33;
    localparam logic [5:0] OP_LBZU   = 6'd35;
    localparam logic [5:0] OP_STWU   = 6'd37;
    localparam logic [5:0] OP_STBU   = 6'd39;
    localparam logic [5:0] OP_LHZU   = 6'd41;
    localparam logic [5:0] OP_LHAU   = 6'd43;
    localparam logic [5:0] OP_STHU   = 6'd45;
    localparam logic [5:0] OP_LMW    = 6'd46;
    localparam logic [5:0] OP_STMW   = 6'd47;
    localparam logic [5:0] OP_DS_LD  = 6'd58;
    localparam logic [5:0] OP_DS_ST  = 6'd62;

    // DS-form sub-opcode (instr[1:0]) selecting the update variant
    localparam logic [1:0] DSXO_UPDATE = 2'd1;

    // X-form extended opcodes (instr[10:1]) of the indexed update forms
    localparam logic [9:0] XO_LDUX  = 10'd53;
    localparam logic [9:0] XO_LWZUX = 10'd55;
    localparam logic [9:0] XO_LBZUX = 10'd119;
    localparam logic [9:0] XO_STDUX = 10'd181;
    localparam logic [9:0] XO_STWUX = 10'd183;
    localparam logic [9:0] XO_STBUX = 10'd247;
    localparam logic [9:0] XO_LHZUX = 10'd311;
    localparam logic [9:0] XO_LWAUX = 10'd373;
    localparam logic [9:0] XO_LHAUX = 10'd375;
    localparam logic [9:0] XO_STHUX = 10'd439;

    localparam logic [5:0] UOPS_ONE    = 6'd1;
    localparam logic [5:0] UOPS_UPDATE = 6'd2;
    localparam logic [5:0] UOPS_MAX    = 6'd32;

    // Load/store-multiple transfers registers RT..31, so the count is 32-RT
    function automatic logic [5:0] multipleCount(input logic [4:0] rt);
        return UOPS_MAX - {1'b0, rt};
    endfunction

endpackage

// File: rtl/uop_commit_merger_count_decode.sv
// Combinational expected-micro-op-count decoder, shared with the cracker's stall logic
// so both ends of the pipe agree on how many micro-ops an instruction becomes.
module uop_count_decode
    import uop_commit_merger_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] i_instr,
    output logic [5:0]             o_expCount
);

    logic [5:0] w_opcd;
    logic [4:0] w_rt;
    logic [9:0] w_xo;
    logic [1:0] w_dsXo;
    logic       w_unused;

    assign w_opcd   = i_instr[31:26];
    assign w_rt     = i_instr[25:21];
    assign w_xo     = i_instr[10:1];
    assign w_dsXo   = i_instr[1:0];
    assign w_unused = ^i_instr[20:11];

    always_comb begin
        o_expCount = UOPS_ONE;
        case (w_opcd)
            OP_LWZU, OP_LBZU, OP_STWU, OP_STBU,
            OP_LHZU, OP_LHAU, OP_STHU:   o_expCount = UOPS_UPDATE;
            OP_LMW, OP_STMW:             o_expCount = multipleCount(w_rt);
            OP_DS_LD, OP_DS_ST: begin
                if (w_dsXo == DSXO_UPDATE) o_expCount = UOPS_UPDATE;
            end
            OP_X_FORM: begin
                case (w_xo)
                    XO_LDUX, XO_LWZUX, XO_LBZUX, XO_STDUX, XO_STWUX,
                    XO_STBUX, XO_LHZUX, XO_LWAUX, XO_LHAUX, XO_STHUX:
                        o_expCount = UOPS_UPDATE;
                    default: o_expCount = UOPS_ONE;
                endcase
            end
            default: o_expCount = UOPS_ONE;
        endcase
    end

endmodule

// File: rtl/uop_commit_merger.sv
// Retire-side regrouping of cracked micro-ops: one architectural commit per original
// instruction, with micro-op count and fault status; stale micro-ops are dropped.
module uop_commit_merger
    import uop_commit_merger_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_uopValid,
    input  logic [PC_WIDTH-1:0]    i_uopPc,
    input  logic [INSTR_WIDTH-1:0] i_uopInstr,
    input  logic                   i_uopFault,
    input  logic                   i_flush,
    output logic                   o_commitValid,
    output logic [PC_WIDTH-1:0]    o_commitPc,
    output logic [INSTR_WIDTH-1:0] o_commitInstr,
    output logic [5:0]             o_commitUops,
    output logic                   o_commitFault,
    output logic                   o_partial,
    output logic                   o_seqErr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GROUP = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GROUP = ST_GROUP,
        DRAIN = ST_DRAIN
    } state_t;

    state_t                 r_state;
    logic [PC_WIDTH-1:0]    r_grpPc;
    logic [INSTR_WIDTH-1:0] r_grpInstr;
    logic [5:0]             r_cnt;
    logic [5:0]             r_rem;

    logic                   r_commitValid;
    logic [PC_WIDTH-1:0]    r_commitPc;
    logic [INSTR_WIDTH-1:0] r_commitInstr;
    logic [5:0]             r_commitUops;
    logic                   r_commitFault;
    logic                   r_partial;
    logic                   r_seqErr;

    state_t                 w_nextState;
    logic [PC_WIDTH-1:0]    w_nextGrpPc;
    logic [INSTR_WIDTH-1:0] w_nextGrpInstr;
    logic [5:0]             w_nextCnt;
    logic [5:0]             w_nextRem;
    logic                   w_fire;
    logic [PC_WIDTH-1:0]    w_firePc;
    logic [INSTR_WIDTH-1:0] w_fireInstr;
    logic [5:0]             w_fireUops;
    logic                   w_fireFault;
    logic                   w_seqSet;

    logic [5:0]             w_expCount;
    logic [5:0]             w_cntInc;
    logic [5:0]             w_remDec;
    logic                   w_pcMatch;
    logic                   w_freshUop;

    uop_count_decode u_countDecode (
        .i_instr    (i_uopInstr),
        .o_expCount (w_expCount)
    );

    assign w_cntInc   = r_cnt + 6'd1;
    assign w_remDec   = r_rem - 6'd1;
    assign w_pcMatch  = (i_uopPc == r_grpPc);
    // A uop with a foreign PC while draining starts a new instruction just like in IDLE
    assign w_freshUop = (r_state == IDLE) || ((r_state == DRAIN) && !w_pcMatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grpPc    <= '0;
            r_grpInstr <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
        end else begin
            r_state    <= w_nextState;
            r_grpPc    <= w_nextGrpPc;
            r_grpInstr <= w_nextGrpInstr;
            r_cnt      <= w_nextCnt;
            r_rem      <= w_nextRem;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextGrpPc    = r_grpPc;
        w_nextGrpInstr = r_grpInstr;
        w_nextCnt      = r_cnt;
        w_nextRem      = r_rem;
        w_fire         = 1'b0;
        w_firePc       = r_grpPc;
        w_fireInstr    = r_grpInstr;
        w_fireUops     = r_cnt;
        w_fireFault    = 1'b0;
        w_seqSet       = 1'b0;

        if (i_flush) begin
            w_nextState = IDLE;
        end else if (i_uopValid) begin
            if (w_freshUop) begin
                w_nextGrpPc    = i_uopPc;
                w_nextGrpInstr = i_uopInstr;
                if ((w_expCount == UOPS_ONE) || i_uopFault) begin
                    w_fire      = 1'b1;
                    w_firePc    = i_uopPc;
                    w_fireInstr = i_uopInstr;
                    w_fireUops  = UOPS_ONE;
                    w_fireFault = i_uopFault;
                    w_nextState = (i_uopFault && (w_expCount != UOPS_ONE)) ? DRAIN : IDLE;
                end else begin
                    w_nextCnt   = UOPS_ONE;
                    w_nextRem   = w_expCount - 6'd1;
                    w_nextState = GROUP;
                end
            end else if (r_state == GROUP) begin
                if (w_pcMatch) begin
                    w_nextCnt = w_cntInc;
                    w_nextRem = w_remDec;
                    if (i_uopFault) begin
                        w_fire      = 1'b1;
                        w_fireUops  = w_cntInc;
                        w_fireFault = 1'b1;
                        w_nextState = (w_remDec != 6'd0) ? DRAIN : IDLE;
                    end else if (w_remDec == 6'd0) begin
                        w_fire      = 1'b1;
                        w_fireUops  = w_cntInc;
                        w_nextState = IDLE;
                    end
                end else begin
                    // PC jumped mid-group: close the group as faulted and drop the intruder
                    w_fire      = 1'b1;
                    w_fireUops  = r_cnt;
                    w_fireFault = 1'b1;
                    w_seqSet    = 1'b1;
                    w_nextState = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commitValid <= 1'b0;
            r_commitPc    <= '0;
            r_commitInstr <= '0;
            r_commitUops  <= '0;
            r_commitFault <= 1'b0;
            r_partial     <= 1'b0;
            r_seqErr      <= 1'b0;
        end else begin
            r_commitValid <= w_fire;
            if (w_fire) begin
                r_commitPc    <= w_firePc;
                r_commitInstr <= w_fireInstr;
                r_commitUops  <= w_fireUops;
                r_commitFault <= w_fireFault;
            end
            r_partial <= (w_nextState == GROUP);
            r_seqErr  <= r_seqErr | w_seqSet;
        end
    end

    assign o_commitValid = r_commitValid;
    assign o_commitPc    = r_commitPc;
    assign o_commitInstr = r_commitInstr;
    assign o_commitUops  = r_commitUops;
    assign o_commitFault = r_commitFault;
    assign o_partial     = r_partial;
    assign o_seqErr      = r_seqErr;

endmodule

// File: tb/tb_uop_commit_merger.sv
// Directed bench for uop_commit_merger: inputs change on the falling edge and
// outputs are checked on the following falling edge.
module tb_uop_commit_merger;

    localparam logic [31:0] ADD    = 32'h7C221A14;
    localparam logic [31:0] LWZU   = 32'h84640008;
    localparam logic [31:0] LMW29  = 32'hBBA10000;
    localparam logic [31:0] LMW0   = 32'hB8010000;
    localparam logic [31:0] STMW28 = 32'hBF810000;
    localparam logic [31:0] LMW28  = 32'hBB810000;
    localparam logic [31:0] STWUX  = 32'h7C00016E;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uopValid;
    logic [31:0] uopPc;
    logic [31:0] uopInstr;
    logic        uopFault;
    logic        flush;
    logic        commitValid;
    logic [31:0] commitPc;
    logic [31:0] commitInstr;
    logic [5:0]  commitUops;
    logic        commitFault;
    logic        partial;
    logic        seqErr;

    int testsRun  = 0;
    int failCount = 0;

    uop_commit_merger dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_uopValid    (uopValid),
        .i_uopPc       (uopPc),
        .i_uopInstr    (uopInstr),
        .i_uopFault    (uopFault),
        .i_flush       (flush),
        .o_commitValid (commitValid),
        .o_commitPc    (commitPc),
        .o_commitInstr (commitInstr),
        .o_commitUops  (commitUops),
        .o_commitFault (commitFault),
        .o_partial     (partial),
        .o_seqErr      (seqErr)
    );

    always #5 clk = ~clk;

    // Present one cycle of inputs, then return at the next falling edge
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic f, input logic fl);
        uopValid = v;
        uopPc    = pc;
        uopInstr = instr;
        uopFault = f;
        flush    = fl;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkCommit(input string tag, input logic [31:0] pc,
                               input logic [5:0] uops, input logic f);
        checkOutput({tag, ".valid"}, {31'd0, commitValid}, 32'd1);
        checkOutput({tag, ".pc"},    commitPc, pc);
        checkOutput({tag, ".uops"},  {26'd0, commitUops}, {26'd0, uops});
        checkOutput({tag, ".fault"}, {31'd0, commitFault}, {31'd0, f});
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".valid"}, {31'd0, commitValid}, 32'd0);
    endtask

    // Every output must read zero, as while reset is asserted
    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".valid"}, {31'd0, commitValid}, 32'd0);
        checkOutput({tag, ".pc"},    commitPc, 32'd0);
        checkOutput({tag, ".instr"}, commitInstr, 32'd0);
        checkOutput({tag, ".uops"},  {26'd0, commitUops}, 32'd0);
        checkOutput({tag, ".fault"}, {31'd0, commitFault}, 32'd0);
        checkOutput({tag, ".partial"}, {31'd0, partial}, 32'd0);
        checkOutput({tag, ".seqErr"},  {31'd0, seqErr}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        uopValid = 1'b0;
        uopPc    = '0;
        uopInstr = '0;
        uopFault = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        // Single-uop add
        applyStimulus(1, 32'h100, ADD, 0, 0);
        checkCommit("add100", 32'h100, 6'd1, 1'b0);
        checkOutput("add100.instr", commitInstr, ADD);
        checkOutput("add100.partial", {31'd0, partial}, 32'd0);
        applyStimulus(0, 32'h0, 32'h0, 0, 0);
        checkQuiet("add100.after");
        checkOutput("add100.hold", commitPc, 32'h100);

        // lwzu: two uops
        applyStimulus(1, 32'h104, LWZU, 0, 0);
        checkQuiet("lwzu.u1");
        checkOutput("lwzu.partial1", {31'd0, partial}, 32'd1);
        applyStimulus(1, 32'h104, LWZU, 0, 0);
        checkCommit("lwzu", 32'h104, 6'd2, 1'b0);
        checkOutput("lwzu.partial2", {31'd0, partial}, 32'd0);

        // lmw r29: three uops, back-to-back after lwzu
        applyStimulus(1, 32'h108, LMW29, 0, 0);
        checkQuiet("lmw29.u1");
        applyStimulus(1, 32'h108, LMW29, 0, 0);
        checkQuiet("lmw29.u2");
        applyStimulus(1, 32'h108, LMW29, 0, 0);
        checkCommit("lmw29", 32'h108, 6'd3, 1'b0);

        // lmw r0: 32 uops, count must not wrap
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1, 32'h180, LMW0, 0, 0);
            checkQuiet("lmw0.mid");
        end
        checkOutput("lmw0.partial", {31'd0, partial}, 32'd1);
        applyStimulus(1, 32'h180, LMW0, 0, 0);
        checkCommit("lmw0", 32'h180, 6'd32, 1'b0);

        // stmw r28 faulting on uop 2, remaining uops drained
        applyStimulus(1, 32'h10C, STMW28, 0, 0);
        checkQuiet("stmw.u1");
        applyStimulus(1, 32'h10C, STMW28, 1, 0);
        checkCommit("stmw.fault", 32'h10C, 6'd2, 1'b1);
        applyStimulus(1, 32'h10C, STMW28, 0, 0);
        checkQuiet("stmw.u3");
        checkOutput("stmw.drainPartial", {31'd0, partial}, 32'd0);
        applyStimulus(1, 32'h10C, STMW28, 0, 0);
        checkQuiet("stmw.u4");
        applyStimulus(1, 32'h110, ADD, 0, 0);
        checkCommit("add110", 32'h110, 6'd1, 1'b0);

        // lmw r28 flushed after two uops; uop in the flush cycle ignored
        applyStimulus(1, 32'h120, LMW28, 0, 0);
        applyStimulus(1, 32'h120, LMW28, 0, 0);
        checkQuiet("lmw28.u2");
        applyStimulus(1, 32'h130, ADD, 0, 1);
        checkQuiet("flush");
        checkOutput("flush.partial", {31'd0, partial}, 32'd0);
        applyStimulus(0, 32'h0, 32'h0, 0, 0);
        checkQuiet("flush.after");
        applyStimulus(1, 32'h134, ADD, 0, 0);
        checkCommit("add134", 32'h134, 6'd1, 1'b0);

        // First-uop fault on a two-uop instruction drains its sibling
        applyStimulus(1, 32'h300, LWZU, 1, 0);
        checkCommit("lwzu300.fault", 32'h300, 6'd1, 1'b1);
        applyStimulus(1, 32'h300, LWZU, 0, 0);
        checkQuiet("lwzu300.drain");

        // Indexed update form counts as two uops
        applyStimulus(1, 32'h500, STWUX, 0, 0);
        checkQuiet("stwux.u1");
        applyStimulus(1, 32'h500, STWUX, 0, 0);
        checkCommit("stwux", 32'h500, 6'd2, 1'b0);

        // Sequence error: PC changes mid-group
        checkOutput("seqErr.before", {31'd0, seqErr}, 32'd0);
        applyStimulus(1, 32'h200, LWZU, 0, 0);
        applyStimulus(1, 32'h204, ADD, 0, 0);
        checkCommit("seqErr", 32'h200, 6'd1, 1'b1);
        checkOutput("seqErr.instr", commitInstr, LWZU);
        checkOutput("seqErr.flag", {31'd0, seqErr}, 32'd1);
        applyStimulus(0, 32'h0, 32'h0, 0, 0);
        checkQuiet("seqErr.dropped");
        applyStimulus(0, 32'h0, 32'h0, 0, 1);
        checkOutput("seqErr.afterFlush", {31'd0, seqErr}, 32'd1);

        // Asynchronous reset mid-group
        applyStimulus(1, 32'h400, LMW28, 0, 0);
        checkOutput("midReset.partial", {31'd0, partial}, 32'd1);
        uopValid = 1'b0;
        flush    = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkAllZero("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 32'h400, LMW28, 0, 0);
        checkQuiet("postReset.u1");
        checkOutput("postReset.partial", {31'd0, partial}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
